// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter and
// the display path downstream of it.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Glyph codes the 7-segment decoder interprets in the sign digit position.
  localparam logic [3:0] GLYPH_MINUS = 4'd10;
  localparam logic [3:0] GLYPH_BLANK = 4'd11;

endpackage : bcd_pkg

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // A digit entering this cell is at most 9, so the result is at most 12.
  assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + 4'd3 : i_digit;

endmodule : bcd_add3_digit

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter with a start/done handshake.
// Define SIGNED_MODE_EN to treat bin as two's complement and add the neg output.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                          overflow
`ifdef SIGNED_MODE_EN
  ,
  output logic                          neg
`endif
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_shift;
  logic [SCR_W-1:0]   r_scratch;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCR_W-1:0]   r_bcd;
  logic               r_overflow;

  logic [WIDTH-1:0]   w_capture;
  logic [SCR_W-1:0]   w_adj;
  logic [SCR_W-1:0]   w_scratch_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic               w_ovf_nxt;
  logic               w_last;

`ifdef SIGNED_MODE_EN
  logic               r_neg_cap;
  logic               r_neg;

  // Negating the most negative value wraps back to 2^(WIDTH-1), which is the
  // correct magnitude when read as unsigned.
  assign w_capture = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;
  assign neg       = r_neg;
`else
  assign w_capture = bin;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_scratch_nxt = {w_adj[SCR_W-2:0], r_shift[WIDTH-1]};
  assign w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
  assign w_ovf_nxt     = r_ovf | w_adj[SCR_W-1];
  assign w_last        = (r_cnt == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next_state = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next_state = FINISH;
      end
      FINISH: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The result registers load on the final shift edge, so they already hold
  // the new value during the FINISH cycle that raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_ovf      <= 1'b0;
      r_cnt      <= '0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
`ifdef SIGNED_MODE_EN
      r_neg_cap  <= 1'b0;
      r_neg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift   <= w_capture;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= CNT_W'(WIDTH);
`ifdef SIGNED_MODE_EN
            r_neg_cap <= bin[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          r_shift   <= w_shift_nxt;
          r_scratch <= w_scratch_nxt;
          r_ovf     <= w_ovf_nxt;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_bcd      <= w_scratch_nxt;
            r_overflow <= w_ovf_nxt;
`ifdef SIGNED_MODE_EN
            r_neg      <= r_neg_cap;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance
// run in lockstep against an arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int W  = 9;
  localparam int D  = 3;
  localparam int D2 = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  bin;
  logic          busy, done, overflow, neg_w;
  logic [4*D-1:0]  bcd;
  logic          busy2, done2, overflow2, neg2_w;
  logic [4*D2-1:0] bcd2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
`ifdef SIGNED_MODE_EN
    , .neg(neg_w)
`endif
  );

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
`ifdef SIGNED_MODE_EN
    , .neg(neg2_w)
`endif
  );

`ifndef SIGNED_MODE_EN
  assign neg_w  = 1'b0;
  assign neg2_w = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the (magnitude of the) operand.
  function automatic void model(input logic [W-1:0] b, input int digits,
                                output logic [11:0] eb, output logic eo, output logic en);
    int v, p, low;
    v  = int'(b);
    en = 1'b0;
`ifdef SIGNED_MODE_EN
    if (b[W-1]) begin
      v  = (1 << W) - v;
      en = 1'b1;
    end
`endif
    p   = 10 ** digits;
    eo  = (v >= p);
    low = v % p;
    eb  = '0;
    for (int i = 0; i < digits; i++) eb[4*i +: 4] = 4'((low / (10 ** i)) % 10);
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic run_conv(input logic [W-1:0] b, output int lat,
                          output logic [11:0] o_bcd, output logic o_ovf,
                          output logic [7:0] o_bcd2, output logic o_ovf2,
                          output logic o_neg);
    bin   = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    o_bcd  = bcd;
    o_ovf  = overflow;
    o_bcd2 = bcd2;
    o_ovf2 = overflow2;
    o_neg  = neg_w;
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] bin;
    logic [11:0]  bcd;
    logic         ovf;
    logic [7:0]   bcd2;
    logic         ovf2;
    logic         neg;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int lat, dcnt, dcyc, first_done, gap;
    logic [11:0] r_bcd, e_bcd, e_bcd2;
    logic [7:0]  r_bcd2;
    logic        r_ovf, r_ovf2, r_neg, e_ovf, e_ovf2, e_neg;
    logic [W-1:0] rb;

`ifdef SIGNED_MODE_EN
    vecs.push_back('{9'h15B, 12'h165, 1'b0, 8'h65, 1'b1, 1'b1});
    vecs.push_back('{9'h100, 12'h256, 1'b0, 8'h56, 1'b1, 1'b1});
    vecs.push_back('{9'h0A5, 12'h165, 1'b0, 8'h65, 1'b1, 1'b0});
    vecs.push_back('{9'h1FF, 12'h001, 1'b0, 8'h01, 1'b0, 1'b1});
    vecs.push_back('{9'h063, 12'h099, 1'b0, 8'h99, 1'b0, 1'b0});
    vecs.push_back('{9'h000, 12'h000, 1'b0, 8'h00, 1'b0, 1'b0});
`else
    vecs.push_back('{9'd165, 12'h165, 1'b0, 8'h65, 1'b1, 1'b0});
    vecs.push_back('{9'd99,  12'h099, 1'b0, 8'h99, 1'b0, 1'b0});
    vecs.push_back('{9'd100, 12'h100, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{9'd511, 12'h511, 1'b0, 8'h11, 1'b1, 1'b0});
    vecs.push_back('{9'd256, 12'h256, 1'b0, 8'h56, 1'b1, 1'b0});
    vecs.push_back('{9'd0,   12'h000, 1'b0, 8'h00, 1'b0, 1'b0});
`endif

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd",  32'(bcd),  32'd0);
    check("reset_ovf",  32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency/busy profile for a single start pulse of 165.
    bin   = 9'd165;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("pulse_busy_c%0d", k), 32'(busy), 32'(k <= 9));
      check($sformatf("pulse_done_c%0d", k), 32'(done), 32'(k == 10));
      if (k == 9)  check("pulse_bcd_stable", 32'(bcd), 32'h000);
      if (k == 10) check("pulse_bcd", 32'(bcd), 32'h165);
    end

    // Table-driven vectors on both instances.
    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, lat, r_bcd, r_ovf, r_bcd2, r_ovf2, r_neg);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
      check($sformatf("vec%0d_bcd", i),  32'(r_bcd),  32'(vecs[i].bcd));
      check($sformatf("vec%0d_ovf", i),  32'(r_ovf),  32'(vecs[i].ovf));
      check($sformatf("vec%0d_bcd2", i), 32'(r_bcd2), 32'(vecs[i].bcd2));
      check($sformatf("vec%0d_ovf2", i), 32'(r_ovf2), 32'(vecs[i].ovf2));
      check($sformatf("vec%0d_neg", i),  32'(r_neg),  32'(vecs[i].neg));
    end

    // Back-to-back with start held: 0 then 511.
    bin        = 9'd0;
    start      = 1'b1;
    dcnt       = 0;
    first_done = 0;
    gap        = 0;
    for (int c = 1; c <= 40 && dcnt < 2; c++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (dcnt == 1) begin
          first_done = c;
          model(9'd0, D, e_bcd, e_ovf, e_neg);
          check("b2b_first_bcd", 32'(bcd), 32'(e_bcd));
          bin = 9'd511;
        end else begin
          gap = c - first_done;
          model(9'd511, D, e_bcd, e_ovf, e_neg);
          check("b2b_second_bcd", 32'(bcd), 32'(e_bcd));
        end
      end
    end
    start = 1'b0;
    check("b2b_done_count", 32'(dcnt), 32'd2);
    check("b2b_gap", 32'(gap), 32'd11);
    repeat (2) @(negedge clk);

    // Start while busy is ignored.
    bin   = 9'd42;
    start = 1'b1;
    @(posedge clk);
    dcnt = 0;
    dcyc = 0;
    r_bcd = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) bin = 9'd99;
      if (done) begin
        dcnt++;
        dcyc  = c;
        r_bcd = bcd;
      end
    end
    check("busy_start_done_count", 32'(dcnt), 32'd1);
    check("busy_start_done_cycle", 32'(dcyc), 32'd10);
    check("busy_start_bcd", 32'(r_bcd), 32'h042);

    // Reset in the middle of a conversion of 300.
    bin   = 9'd300;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd",  32'(bcd),  32'd0);
    check("abort_ovf",  32'(overflow2), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dcnt  = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    run_conv(9'd7, lat, r_bcd, r_ovf, r_bcd2, r_ovf2, r_neg);
    check("after_abort_latency", 32'(lat), 32'd10);
    check("after_abort_bcd", 32'(r_bcd), 32'h007);

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      rb = W'($urandom_range(0, (1 << W) - 1));
      run_conv(rb, lat, r_bcd, r_ovf, r_bcd2, r_ovf2, r_neg);
      model(rb, D, e_bcd, e_ovf, e_neg);
      model(rb, D2, e_bcd2, e_ovf2, e_neg);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd10);
      check($sformatf("rnd%0d_bcd_%0h", i, rb), 32'(r_bcd), 32'(e_bcd));
      check($sformatf("rnd%0d_ovf_%0h", i, rb), 32'(r_ovf), 32'(e_ovf));
      check($sformatf("rnd%0d_bcd2_%0h", i, rb), 32'(r_bcd2), 32'(e_bcd2[7:0]));
      check($sformatf("rnd%0d_ovf2_%0h", i, rb), 32'(r_ovf2), 32'(e_ovf2));
      check($sformatf("rnd%0d_neg_%0h", i, rb), 32'(r_neg), 32'(e_neg));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bin_to_bcd_seq
